rvx_core_prefetch_buffer: RTL and testbench



---
 rtl/rvx_core_prefetch_buffer.sv | 141 ++++++++++++++
 tb/tb_rvx_core_prefetch_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_core_prefetch_buffer.sv
// Instruction prefetch buffer: DEPTH-entry FIFO of {pc, instruction} pairs feeding decode.
// Optional macro RVX_PREFETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module rvx_core_prefetch_buffer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
    parameter int          DEPTH        = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_rresponse,
    output logic [31:0] ibus_address,
    output logic        ibus_rrequest,
    input  logic        redirect_s1,
    input  logic [31:0] redirect_address_s1,
    input  logic        instruction_ready_s1,
    output logic        instruction_valid_s1,
    output logic [31:0] instruction_s1,
    output logic [31:0] program_counter_s1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      discard_address;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic push;
    logic pop;
    logic bypass_take;
    logic write_en;
    logic read_adv;
    logic unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_address_s1[1:0];

    assign ibus_rrequest = (state == REQUEST) || (state == DISCARD);
    assign ibus_address  = (state == DISCARD) ? discard_address : {fetch_pc[31:2], 2'b00};

    assign push = (state == REQUEST) && ibus_rresponse && !redirect_s1;

    // Decode handshake: an entry transfers on a cycle where valid and ready are both high;
    // valid never depends on ready, and a redirect cancels any transfer in that cycle.
`ifdef RVX_PREFETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit           = (count == '0) && push;
    assign instruction_valid_s1 = (count != '0) || bypass_hit;
    assign instruction_s1       = bypass_hit ? ibus_rdata : instr_mem[rd_ptr];
    assign program_counter_s1   = bypass_hit ? {fetch_pc[31:2], 2'b00} : pc_mem[rd_ptr];
    assign bypass_take          = bypass_hit && instruction_ready_s1;
`else
    assign instruction_valid_s1 = (count != '0);
    assign instruction_s1       = instr_mem[rd_ptr];
    assign program_counter_s1   = pc_mem[rd_ptr];
    assign bypass_take          = 1'b0;
`endif

    assign pop = instruction_valid_s1 && instruction_ready_s1 && !redirect_s1;

    // A consumed bypass is a push and pop of the same word, so storage and pointers stay put.
    assign write_en = push && !bypass_take;
    assign read_adv = pop && !bypass_take;

    assign next_count = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            fetch_pc        <= BOOT_ADDRESS;
            discard_address <= BOOT_ADDRESS;
            count           <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
        end else if (redirect_s1) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {redirect_address_s1[31:2], 2'b00};
            case (state)
                IDLE: state <= REQUEST;
                REQUEST: begin
                    if (ibus_rresponse) begin
                        state <= REQUEST;
                    end else begin
                        // Keep the bus request stable until its response drains.
                        discard_address <= {fetch_pc[31:2], 2'b00};
                        state           <= DISCARD;
                    end
                end
                DISCARD: state <= ibus_rresponse ? REQUEST : DISCARD;
                default: state <= IDLE;
            endcase
        end else begin
            count <= next_count;
            if (write_en) wr_ptr <= wr_ptr + 1'b1;
            if (read_adv) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) state <= REQUEST;
                end
                REQUEST: begin
                    if (push) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (next_count >= DEPTH_C) state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (ibus_rresponse) state <= REQUEST;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= BOOT_ADDRESS;
                instr_mem[i] <= NOP;
            end
        end else if (write_en) begin
            pc_mem[wr_ptr]    <= {fetch_pc[31:2], 2'b00};
            instr_mem[wr_ptr] <= ibus_rdata;
        end
    end

endmodule

// File: tb/tb_rvx_core_prefetch_buffer.sv
// Directed bench for rvx_core_prefetch_buffer with a latency-programmable single-outstanding bus model.
module tb_rvx_core_prefetch_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ibus_rdata;
    logic        ibus_rresponse;
    logic [31:0] ibus_address;
    logic        ibus_rrequest;
    logic        redirect_s1;
    logic [31:0] redirect_address_s1;
    logic        instruction_ready_s1;
    logic        instruction_valid_s1;
    logic [31:0] instruction_s1;
    logic [31:0] program_counter_s1;

    int checks   = 0;
    int failures = 0;

    int          bus_latency = 0;
    int          bus_age     = 0;
    int          resp_count  = 0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_data  = 32'h0;

    rvx_core_prefetch_buffer #(
        .BOOT_ADDRESS(32'h00000000),
        .DEPTH       (4)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .ibus_rdata          (ibus_rdata),
        .ibus_rresponse      (ibus_rresponse),
        .ibus_address        (ibus_address),
        .ibus_rrequest       (ibus_rrequest),
        .redirect_s1         (redirect_s1),
        .redirect_address_s1 (redirect_address_s1),
        .instruction_ready_s1(instruction_ready_s1),
        .instruction_valid_s1(instruction_valid_s1),
        .instruction_s1      (instruction_s1),
        .program_counter_s1  (program_counter_s1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Bus answers the current request after bus_latency idle cycles; data is the address unless fixed.
    task automatic bus_update();
        if (ibus_rrequest === 1'b1) begin
            if (bus_age >= bus_latency) begin
                ibus_rresponse = 1'b1;
                ibus_rdata     = use_fixed ? fixed_data : ibus_address;
                resp_count++;
                bus_age = 0;
            end else begin
                ibus_rresponse = 1'b0;
                ibus_rdata     = 32'h0;
                bus_age++;
            end
        end else begin
            ibus_rresponse = 1'b0;
            ibus_rdata     = 32'h0;
            bus_age        = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus_update();
        #1;
    endtask

    task automatic assert_reset();
        reset_n             = 1'b0;
        ibus_rresponse      = 1'b0;
        ibus_rdata          = 32'h0;
        redirect_s1         = 1'b0;
        redirect_address_s1 = 32'h0;
        bus_age             = 0;
        resp_count          = 0;
        use_fixed           = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        bus_age = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n              = 1'b1;
        instruction_ready_s1 = 1'b1;
        redirect_s1          = 1'b0;
        redirect_address_s1  = 32'h0;
        ibus_rresponse       = 1'b0;
        ibus_rdata           = 32'h0;
        #1;

        // Reset values, then zero-wait streaming with decode always ready
        assert_reset();
        bus_latency = 0;
        #1;
        check("rst_rrequest", {31'b0, ibus_rrequest}, 32'd0);
        check("rst_valid", {31'b0, instruction_valid_s1}, 32'd0);
        check("rst_instr", instruction_s1, 32'h00000013);
        check("rst_pc", program_counter_s1, 32'h0);
        check("rst_address", ibus_address, 32'h0);
        release_reset();
        check("release_no_req", {31'b0, ibus_rrequest}, 32'd0);
        tick();
        check("first_req", {31'b0, ibus_rrequest}, 32'd1);
        check("first_addr", ibus_address, 32'h0);
        check("first_valid", {31'b0, instruction_valid_s1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stream_valid", {31'b0, instruction_valid_s1}, 32'd1);
            check("stream_pc", program_counter_s1, 32'(4 * i));
            check("stream_instr", instruction_s1, 32'(4 * i));
            check("stream_addr", ibus_address, 32'(4 * (i + 1)));
        end

        // Fill to full with decode stalled, then release one slot
        assert_reset();
        instruction_ready_s1 = 1'b0;
        bus_latency = 0;
        release_reset();
        repeat (5) tick();
        check("full_rrequest", {31'b0, ibus_rrequest}, 32'd0);
        check("full_resp_count", 32'(resp_count), 32'd4);
        check("full_valid", {31'b0, instruction_valid_s1}, 32'd1);
        check("full_pc", program_counter_s1, 32'h0);
        check("full_instr", instruction_s1, 32'h0);
        repeat (2) tick();
        check("full_hold_rrequest", {31'b0, ibus_rrequest}, 32'd0);
        check("full_hold_resp_count", 32'(resp_count), 32'd4);
        check("full_hold_pc", program_counter_s1, 32'h0);
        instruction_ready_s1 = 1'b1;
        tick();
        instruction_ready_s1 = 1'b0;
        #1;
        check("pop_pc", program_counter_s1, 32'h4);
        check("pop_still_idle", {31'b0, ibus_rrequest}, 32'd0);
        tick();
        check("refill_req", {31'b0, ibus_rrequest}, 32'd1);
        check("refill_addr", ibus_address, 32'h10);
        tick();
        check("refill_full", {31'b0, ibus_rrequest}, 32'd0);
        check("refill_resp_count", 32'(resp_count), 32'd5);
        check("refill_hold_pc", program_counter_s1, 32'h4);

        // Redirect while the request to 0x8 waits on a slow bus
        assert_reset();
        instruction_ready_s1 = 1'b1;
        bus_latency = 2;
        release_reset();
        for (int i = 0; i < 20 && !(ibus_rrequest === 1'b1 && ibus_address === 32'h8); i++) tick();
        check("reach_addr8", ibus_address, 32'h8);
        redirect_s1         = 1'b1;
        redirect_address_s1 = 32'h00000203;
        tick();
        redirect_s1 = 1'b0;
        #1;
        check("discard_valid", {31'b0, instruction_valid_s1}, 32'd0);
        check("discard_req", {31'b0, ibus_rrequest}, 32'd1);
        check("discard_addr_hold", ibus_address, 32'h8);
        tick();
        check("discard_addr_hold2", ibus_address, 32'h8);
        tick();
        check("after_discard_addr", ibus_address, 32'h200);
        check("after_discard_valid", {31'b0, instruction_valid_s1}, 32'd0);
        for (int i = 0; i < 10 && instruction_valid_s1 !== 1'b1; i++) tick();
        check("redir_valid", {31'b0, instruction_valid_s1}, 32'd1);
        check("redir_pc", program_counter_s1, 32'h200);
        check("redir_instr", instruction_s1, 32'h200);

        // Redirect coinciding with a response and a pop
        assert_reset();
        instruction_ready_s1 = 1'b1;
        bus_latency = 0;
        release_reset();
        repeat (3) tick();
        check("pre_redir_valid", {31'b0, instruction_valid_s1}, 32'd1);
        redirect_s1         = 1'b1;
        redirect_address_s1 = 32'h00001000;
        bus_latency         = 1;
        tick();
        redirect_s1 = 1'b0;
        #1;
        check("same_cycle_valid", {31'b0, instruction_valid_s1}, 32'd0);
        check("same_cycle_addr", ibus_address, 32'h1000);
        check("same_cycle_req", {31'b0, ibus_rrequest}, 32'd1);
        for (int i = 0; i < 10 && instruction_valid_s1 !== 1'b1; i++) tick();
        check("same_cycle_next_pc", program_counter_s1, 32'h1000);

        // Asynchronous reset in the middle of a request with three entries held
        assert_reset();
        instruction_ready_s1 = 1'b0;
        bus_latency = 0;
        release_reset();
        repeat (4) tick();
        check("pre_async_req", {31'b0, ibus_rrequest}, 32'd1);
        check("pre_async_addr", ibus_address, 32'hC);
        reset_n        = 1'b0;
        ibus_rresponse = 1'b0;
        #1;
        check("async_rrequest", {31'b0, ibus_rrequest}, 32'd0);
        check("async_valid", {31'b0, instruction_valid_s1}, 32'd0);
        check("async_instr", instruction_s1, 32'h00000013);
        check("async_pc", program_counter_s1, 32'h0);
        check("async_addr", ibus_address, 32'h0);
        release_reset();
        tick();
        check("restart_req", {31'b0, ibus_rrequest}, 32'd1);
        check("restart_addr", ibus_address, 32'h0);
        tick();
        check("restart_pc", program_counter_s1, 32'h0);

`ifdef RVX_PREFETCH_BYPASS_EN
        // Empty buffer forwards the response in the same cycle
        assert_reset();
        instruction_ready_s1 = 1'b1;
        bus_latency = 0;
        use_fixed   = 1'b1;
        fixed_data  = 32'hDEADBEEF;
        release_reset();
        redirect_s1         = 1'b1;
        redirect_address_s1 = 32'h00000040;
        tick();
        redirect_s1 = 1'b0;
        #1;
        check("bypass_valid", {31'b0, instruction_valid_s1}, 32'd1);
        check("bypass_instr", instruction_s1, 32'hDEADBEEF);
        check("bypass_pc", program_counter_s1, 32'h40);
        bus_latency = 1;
        tick();
        check("bypass_count_zero", {31'b0, instruction_valid_s1}, 32'd0);
        check("bypass_next_addr", ibus_address, 32'h44);
        use_fixed = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
